// File: rtl/pr_decouple_pipe.sv
// Valid/ready pipeline slice for streams crossing a partial-reconfiguration boundary.
// Cascaded forward or skid stages with decouple isolation, flush and an occupancy count.
module pr_decouple_pipe #(
    parameter int DATA_WIDTH       = 128,
    parameter int REG_LENGTH       = 2,
    parameter int REG_TYPE         = 2,
    parameter bit DROP_ON_DECOUPLE = 1'b1,
    // A zero-stage pipe still needs a 1-bit occupancy port.
    parameter int CNT_WIDTH        = (REG_LENGTH == 0) ? 1 : $clog2(2 * REG_LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  decouple,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  decouple_ack
);

    localparam bit BYPASS  = (REG_TYPE == 0) || (REG_LENGTH == 0);
    localparam int MAX_OCC = BYPASS ? 0 : ((REG_TYPE == 1) ? REG_LENGTH : 2 * REG_LENGTH);

    logic gate;
    logic decouple_ack_q, decouple_ack_d;

    assign gate = decouple | flush | rst;

    always_comb decouple_ack_d = decouple;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) decouple_ack_q <= 1'b0;
        else     decouple_ack_q <= decouple_ack_d;
    end

    assign decouple_ack = decouple_ack_q;

    if (BYPASS) begin : g_bypass
        assign m_data    = s_data;
        assign m_valid   = s_valid & ~gate;
        assign s_ready   = m_ready & ~gate;
        assign occupancy = '0;
    end else begin : g_pipe
        logic                  clear;
        logic                  accept, emit;
        logic [CNT_WIDTH-1:0]  occ_q, occ_d;
        logic                  c_valid [REG_LENGTH+1];
        logic [DATA_WIDTH-1:0] c_data  [REG_LENGTH+1];
        logic                  c_ready [REG_LENGTH+1];

        // Drop happens only on the first decouple cycle; ack still low marks the rise.
        assign clear = flush | (DROP_ON_DECOUPLE & decouple & ~decouple_ack_q);

        assign c_valid[0]          = s_valid & ~gate;
        assign c_data[0]           = s_data;
        assign s_ready             = c_ready[0] & ~gate;
        assign m_valid             = c_valid[REG_LENGTH] & ~gate;
        assign m_data              = c_data[REG_LENGTH];
        assign c_ready[REG_LENGTH] = m_ready & ~gate;

        assign accept = s_valid & s_ready;
        assign emit   = m_valid & m_ready;

        always_comb begin
            occ_d = occ_q;
            if (clear) occ_d = '0;
            else       occ_d = occ_q + CNT_WIDTH'(accept) - CNT_WIDTH'(emit);
        end

        always_ff @(posedge clk) begin
            if (rst) occ_q <= '0;
            else     occ_q <= occ_d;
            if (!rst && !clear) begin
                assert (occ_q <= CNT_WIDTH'(MAX_OCC));
                assert (!(accept && !emit && occ_q == CNT_WIDTH'(MAX_OCC)));
                assert (!(emit && !accept && occ_q == '0));
            end
        end

        assign occupancy = occ_q;

        for (genvar i = 0; i < REG_LENGTH; i++) begin : g_stage
            if (REG_TYPE == 1) begin : g_fwd
                logic                  valid_q, valid_d;
                logic [DATA_WIDTH-1:0] data_q, data_d;
                logic                  load;

                assign load = ~valid_q | c_ready[i+1];

                // NOTE: every always_comb output gets a default first, so no latch is inferred.
                always_comb begin
                    valid_d = valid_q;
                    data_d  = data_q;
                    if (load) begin
                        valid_d = c_valid[i];
                        if (c_valid[i]) data_d = c_data[i];
                    end
                    if (clear) valid_d = 1'b0;
                end

                always_ff @(posedge clk) begin
                    if (rst) valid_q <= 1'b0;
                    else     valid_q <= valid_d;
                end

                // NOTE: payload registers are not reset; the valid bits alone define contents.
                always_ff @(posedge clk) data_q <= data_d;

                assign c_ready[i]   = load;
                assign c_valid[i+1] = valid_q;
                assign c_data[i+1]  = data_q;
            end else begin : g_skid
                logic                  main_valid_q, main_valid_d;
                logic                  skid_valid_q, skid_valid_d;
                logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
                logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
                logic                  take, main_free;

                assign take      = c_valid[i] & ~skid_valid_q;
                assign main_free = ~main_valid_q | c_ready[i+1];

                always_comb begin
                    main_valid_d = main_valid_q;
                    main_data_d  = main_data_q;
                    skid_valid_d = skid_valid_q;
                    skid_data_d  = skid_data_q;
                    if (main_free) begin
                        if (skid_valid_q) begin
                            main_valid_d = 1'b1;
                            main_data_d  = skid_data_q;
                            skid_valid_d = 1'b0;
                        end else begin
                            main_valid_d = take;
                            if (take) main_data_d = c_data[i];
                        end
                    end else if (take) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = c_data[i];
                    end
                    if (clear) begin
                        main_valid_d = 1'b0;
                        skid_valid_d = 1'b0;
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        main_valid_q <= 1'b0;
                        skid_valid_q <= 1'b0;
                    end else begin
                        main_valid_q <= main_valid_d;
                        skid_valid_q <= skid_valid_d;
                    end
                end

                always_ff @(posedge clk) begin
                    main_data_q <= main_data_d;
                    skid_data_q <= skid_data_d;
                end

                // Upstream ready comes straight from a flop, cutting the m_ready path.
                assign c_ready[i]   = ~skid_valid_q;
                assign c_valid[i+1] = main_valid_q;
                assign c_data[i+1]  = main_data_q;
            end
        end
    end

endmodule

// File: tb/tb_pr_decouple_pipe.sv
// Scoreboard bench for pr_decouple_pipe: three instances (skid/drop, forward/drop, skid/hold)
// share control inputs; each has its own producer and reference queue.
module tb_pr_decouple_pipe;

    localparam int NI = 3;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] data;
        int            t_acc;
    } beat_t;

    function automatic int rt_of(input int k);
        return (k == 1) ? 1 : 2;
    endfunction
    function automatic int len_of(input int k);
        return (k == 1) ? 3 : 2;
    endfunction
    function automatic bit drop_of(input int k);
        return (k != 2);
    endfunction
    function automatic int max_of(input int k);
        return (rt_of(k) == 2) ? 2 * len_of(k) : len_of(k);
    endfunction

    logic          clk = 1'b0;
    logic          rst, decouple, flush, m_ready;
    logic          s_valid   [NI];
    logic [DW-1:0] s_data    [NI];
    logic          s_ready_a [NI];
    logic          m_valid_a [NI];
    logic          ack_a     [NI];
    logic [DW-1:0] m_data_a  [NI];
    logic [2:0]    occ_a     [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        pr_decouple_pipe #(
            .DATA_WIDTH      (DW),
            .REG_LENGTH      (len_of(k)),
            .REG_TYPE        (rt_of(k)),
            .DROP_ON_DECOUPLE(drop_of(k))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .decouple    (decouple),
            .flush       (flush),
            .s_data      (s_data[k]),
            .s_valid     (s_valid[k]),
            .s_ready     (s_ready_a[k]),
            .m_data      (m_data_a[k]),
            .m_valid     (m_valid_a[k]),
            .m_ready     (m_ready),
            .occupancy   (occ_a[k]),
            .decouple_ack(ack_a[k])
        );
    end

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    bit    started = 1'b0;
    bit    strict = 1'b0;
    bit    prev_dec = 1'b0;
    beat_t sb [NI][$];
    int    n_emit [NI] = '{0, 0, 0};
    beat_t mon_head;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string what, input int k, input longint got, input longint exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h (cycle %0d)", what, k, got, exp, cyc);
        end
    endtask

    // Monitor: compares every presented beat with the head of the reference queue.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < NI; k++) begin
                check(int'(occ_a[k]) == sb[k].size(), "occupancy", k, occ_a[k], sb[k].size());
                check(int'(occ_a[k]) <= max_of(k), "occupancy_max", k, occ_a[k], max_of(k));
                check(ack_a[k] == prev_dec, "decouple_ack", k, ack_a[k], prev_dec);
                if (rst || flush || decouple)
                    check(!s_ready_a[k] && !m_valid_a[k], "gating", k, {s_ready_a[k], m_valid_a[k]}, 0);
                if (m_valid_a[k] == 1'b1) begin
                    check(sb[k].size() != 0, "unexpected_beat", k, m_data_a[k], 0);
                    if (sb[k].size() != 0) begin
                        mon_head = sb[k][0];
                        check(m_data_a[k] == mon_head.data, "m_data", k, m_data_a[k], mon_head.data);
                        if (m_ready) begin
                            void'(sb[k].pop_front());
                            n_emit[k]++;
                            check(cyc - mon_head.t_acc >= len_of(k), "latency_min", k,
                                  cyc - mon_head.t_acc, len_of(k));
                            if (strict)
                                check(cyc - mon_head.t_acc == len_of(k), "latency", k,
                                      cyc - mon_head.t_acc, len_of(k));
                        end
                    end
                end
            end
        end
    end

    bit            acc       [NI];
    int            pend      [NI];
    logic [DW-1:0] nxt       [NI];
    int            phase_acc [NI];
    int            first_acc [NI];
    int            last_acc  [NI];
    int            base_emit [NI];
    logic          smp_sr    [NI];
    logic          smp_mv    [NI];
    logic          smp_ack   [NI];
    logic [2:0]    smp_occ   [NI];
    logic [DW-1:0] smp_md    [NI];
    bit            rnd = 1'b0;

    // One clock cycle: record handshakes into the reference model, then drive the producers.
    task automatic step();
        beat_t b;
        @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            smp_sr[k]  = s_ready_a[k];
            smp_mv[k]  = m_valid_a[k];
            smp_ack[k] = ack_a[k];
            smp_occ[k] = occ_a[k];
            smp_md[k]  = m_data_a[k];
            acc[k]     = s_valid[k] && s_ready_a[k];
            if (acc[k]) begin
                b.data  = s_data[k];
                b.t_acc = cyc;
                sb[k].push_back(b);
                if (phase_acc[k] == 0) first_acc[k] = cyc;
                last_acc[k] = cyc;
                phase_acc[k]++;
            end
            if (rst || flush || (drop_of(k) && decouple && !prev_dec)) sb[k].delete();
        end
        prev_dec = rst ? 1'b0 : decouple;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            if (acc[k]) begin
                pend[k]--;
                nxt[k] = rnd ? DW'($urandom) : nxt[k] + 1'b1;
            end
            if (pend[k] <= 0) s_valid[k] = 1'b0;
            else if (!(s_valid[k] && !acc[k])) s_valid[k] = rnd ? ($urandom_range(3) != 0) : 1'b1;
            s_data[k] = nxt[k];
        end
    endtask

    task automatic set_all(input int p, input logic [DW-1:0] start);
        for (int k = 0; k < NI; k++) begin
            pend[k]      = p;
            nxt[k]       = start;
            phase_acc[k] = 0;
            base_emit[k] = n_emit[k];
        end
    endtask

    initial begin
        rst = 1'b1; decouple = 1'b0; flush = 1'b0; m_ready = 1'b0;
        for (int k = 0; k < NI; k++) begin
            s_valid[k] = 1'b0; s_data[k] = '0;
        end
        set_all(0, 16'h1);

        // Reset state
        step();
        started = 1'b1;
        step();
        for (int k = 0; k < NI; k++) begin
            check(smp_sr[k] == 1'b0, "reset_s_ready", k, smp_sr[k], 0);
            check(smp_mv[k] == 1'b0, "reset_m_valid", k, smp_mv[k], 0);
            check(smp_occ[k] == 3'd0, "reset_occupancy", k, smp_occ[k], 0);
            check(smp_ack[k] == 1'b0, "reset_ack", k, smp_ack[k], 0);
        end
        rst = 1'b0;
        step();
        for (int k = 0; k < NI; k++) check(smp_sr[k] == 1'b1, "post_reset_s_ready", k, smp_sr[k], 1);

        // Back-to-back stream 0x1..0x10 with m_ready high
        m_ready = 1'b1;
        strict  = 1'b1;
        set_all(16, 16'h1);
        repeat (22) step();
        strict = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check(phase_acc[k] == 16, "stream_accepts", k, phase_acc[k], 16);
            check(last_acc[k] - first_acc[k] == 15, "stream_span", k, last_acc[k] - first_acc[k], 15);
            check(n_emit[k] - base_emit[k] == 16, "stream_emits", k, n_emit[k] - base_emit[k], 16);
        end

        // Fill until full, then drain on consecutive cycles
        m_ready = 1'b0;
        set_all(100, 16'h1);
        repeat (10) step();
        for (int k = 0; k < NI; k++) begin
            check(phase_acc[k] == max_of(k), "capacity", k, phase_acc[k], max_of(k));
            check(int'(smp_occ[k]) == max_of(k), "full_occupancy", k, smp_occ[k], max_of(k));
            check(smp_sr[k] == 1'b0, "full_s_ready", k, smp_sr[k], 0);
        end
        set_all(0, 16'h80);
        m_ready = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            step();
            for (int k = 0; k < NI; k++)
                if (s == max_of(k))
                    check(n_emit[k] - base_emit[k] == max_of(k), "drain_consecutive", k,
                          n_emit[k] - base_emit[k], max_of(k));
        end
        repeat (2) step();
        for (int k = 0; k < NI; k++) check(smp_occ[k] == 3'd0, "drained", k, smp_occ[k], 0);

        // Alternating m_ready with continuous s_valid
        set_all(40, 16'h100);
        for (int s = 0; s < 60; s++) begin
            m_ready = ~s[0];
            step();
            if (smp_occ[1] == 3'd3) check(smp_sr[1] == m_ready, "full_ready_follows", 1, smp_sr[1], m_ready);
        end
        m_ready = 1'b1;
        set_all(0, 16'h0);
        repeat (10) step();

        // Decouple with three beats held
        m_ready = 1'b0;
        set_all(3, 16'hA);
        repeat (5) step();
        for (int k = 0; k < NI; k++) check(smp_occ[k] == 3'd3, "pre_decouple_occ", k, smp_occ[k], 3);
        m_ready  = 1'b1;
        decouple = 1'b1;
        set_all(2, 16'h20);
        step();
        for (int k = 0; k < NI; k++)
            check(!smp_sr[k] && !smp_mv[k], "decouple_first_cycle", k, {smp_sr[k], smp_mv[k]}, 0);
        step();
        for (int k = 0; k < NI; k++)
            check(int'(smp_occ[k]) == (drop_of(k) ? 0 : 3), "decouple_occ", k, smp_occ[k], drop_of(k) ? 0 : 3);
        repeat (3) step();
        decouple = 1'b0;
        step();
        for (int k = 0; k < NI; k++) check(smp_mv[k] == !drop_of(k), "release_m_valid", k, smp_mv[k], !drop_of(k));
        check(smp_md[2] == 16'hA, "release_first_held", 2, smp_md[2], 16'hA);
        repeat (10) step();

        // Flush with s_valid high, then reset mid-stream
        m_ready = 1'b0;
        set_all(2, 16'h50);
        repeat (5) step();
        for (int k = 0; k < NI; k++) check(smp_occ[k] == 3'd2, "pre_flush_occ", k, smp_occ[k], 2);
        set_all(10, 16'h60);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < NI; k++) check(phase_acc[k] == 0, "flush_no_accept", k, phase_acc[k], 0);
        step();
        for (int k = 0; k < NI; k++) check(smp_occ[k] == 3'd0, "post_flush_occ", k, smp_occ[k], 0);
        m_ready = 1'b1;
        repeat (3) step();
        rst      = 1'b1;
        decouple = 1'b1;
        step();
        rst      = 1'b0;
        decouple = 1'b0;
        step();
        for (int k = 0; k < NI; k++) begin
            check(smp_mv[k] == 1'b0, "post_rst_m_valid", k, smp_mv[k], 0);
            check(smp_occ[k] == 3'd0, "post_rst_occ", k, smp_occ[k], 0);
            check(smp_ack[k] == 1'b0, "post_rst_ack", k, smp_ack[k], 0);
        end
        repeat (8) step();

        // Randomised traffic with flush and decouple pulses
        rnd = 1'b1;
        set_all(1000000, DW'($urandom));
        for (int s = 0; s < 800; s++) begin
            m_ready = ($urandom_range(3) != 0);
            flush   = ($urandom_range(39) == 0);
            if (decouple) decouple = ($urandom_range(3) != 0);
            else          decouple = ($urandom_range(29) == 0);
            step();
        end
        rnd      = 1'b0;
        flush    = 1'b0;
        decouple = 1'b0;
        m_ready  = 1'b1;
        set_all(0, 16'h0);
        repeat (20) step();
        for (int k = 0; k < NI; k++) begin
            check(sb[k].size() == 0, "final_empty", k, sb[k].size(), 0);
            check(smp_occ[k] == 3'd0, "final_occ", k, smp_occ[k], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
